// File: rtl/rect_wave_gen.sv
// Rectangular/trapezoidal waveform sequencer: delay, rise ramp, high, fall ramp, low.
// Optional build macro RECT_WAVE_GEN_CYCLES_EN adds a saturating completed-period counter output.
module rect_wave_gen #(
    parameter int DW = 12,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          periodic,
    input  logic [DW-1:0] iv,
    input  logic [DW-1:0] pv,
    input  logic [DW-1:0] step_r,
    input  logic [DW-1:0] step_f,
    input  logic [CW-1:0] td,
    input  logic [CW-1:0] tr,
    input  logic [CW-1:0] th,
    input  logic [CW-1:0] tf,
    input  logic [CW-1:0] tl,
    output logic [DW-1:0] dout,
    output logic          busy,
    output logic          done,
    output logic [2:0]    phase
`ifdef RECT_WAVE_GEN_CYCLES_EN
    ,
    output logic [15:0]   cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_RISE  = 3'd2,
        S_HIGH  = 3'd3,
        S_FALL  = 3'd4,
        S_LOW   = 3'd5
    } state_t;

    localparam logic [CW-1:0] CNT_ONE = 1;

    state_t        state_q, state_d, nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          done_q, done_d;
    logic [DW-1:0] iv_q, iv_d, pv_q, pv_d, sr_q, sr_d, sf_q, sf_d;
    logic [CW-1:0] td_q, td_d, tr_q, tr_d, th_q, th_d, tf_q, tf_d, tl_q, tl_d;
    logic          per_q, per_d;
    logic [5:1]    nz_in, nz_q;
`ifdef RECT_WAVE_GEN_CYCLES_EN
    logic [15:0]   cyc_q, cyc_d;
`endif

    // First state at or after 'from' with nonzero duration; periodic runs wrap back to RISE.
    function automatic state_t pick(input logic [2:0] from, input logic [5:1] nz, input logic per);
        state_t r;
        r = S_IDLE;
        for (int i = 1; i <= 5; i++)
            if (r == S_IDLE && i >= int'(from) && nz[i]) r = state_t'(i[2:0]);
        if (per)
            for (int i = 2; i <= 5; i++)
                if (r == S_IDLE && nz[i]) r = state_t'(i[2:0]);
        return r;
    endfunction

    function automatic logic [CW-1:0] dur_of(input state_t s, input logic [CW-1:0] d0, d1, d2, d3, d4);
        logic [CW-1:0] r;
        case (s)
            S_DELAY: r = d0;
            S_RISE:  r = d1;
            S_HIGH:  r = d2;
            S_FALL:  r = d3;
            S_LOW:   r = d4;
            default: r = '0;
        endcase
        return r;
    endfunction

    // One ramp step toward tgt, clamped; widened by one bit so neither end can wrap.
    function automatic logic [DW-1:0] ramp(input logic [DW-1:0] prev, tgt, step);
        logic [DW:0] p, t, s, sum;
        logic [DW-1:0] r;
        p   = {1'b0, prev};
        t   = {1'b0, tgt};
        s   = {1'b0, step};
        sum = p + s;
        if (p <= t) r = (sum >= t) ? tgt : sum[DW-1:0];
        else        r = (p <= t + s) ? tgt : prev - step;
        return r;
    endfunction

    function automatic logic [DW-1:0] level(input state_t s, input logic [CW-1:0] cnt,
                                            input logic [DW-1:0] prev, ivv, pvv, sr, sf);
        logic [DW-1:0] r;
        case (s)
            S_RISE:  r = (cnt == '0) ? pvv : ramp(prev, pvv, sr);
            S_HIGH:  r = pvv;
            S_FALL:  r = (cnt == '0) ? ivv : ramp(prev, ivv, sf);
            default: r = ivv;
        endcase
        return r;
    endfunction

    assign nz_in = {periodic && (tl != '0), tf != '0, th != '0, tr != '0, td != '0};
    assign nz_q  = {per_q && (tl_q != '0), tf_q != '0, th_q != '0, tr_q != '0, td_q != '0};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        iv_d = iv_q; pv_d = pv_q; sr_d = sr_q; sf_d = sf_q;
        td_d = td_q; tr_d = tr_q; th_d = th_q; tf_d = tf_q; tl_d = tl_q;
        per_d = per_q;
        nxt     = S_IDLE;
`ifdef RECT_WAVE_GEN_CYCLES_EN
        cyc_d   = cyc_q;
`endif
        if (state_q == S_IDLE) begin
            if (start && !stop) begin
                iv_d = iv; pv_d = pv; sr_d = step_r; sf_d = step_f;
                td_d = td; tr_d = tr; th_d = th; tf_d = tf; tl_d = tl;
                per_d   = periodic;
                nxt     = pick(3'd1, nz_in, periodic);
                state_d = nxt;
                cnt_d   = (nxt == S_IDLE) ? '0 : dur_of(nxt, td, tr, th, tf, tl) - CNT_ONE;
                dout_d  = level(nxt, cnt_d, iv, iv, pv, step_r, step_f);
                done_d  = (nxt == S_IDLE) && !periodic;
`ifdef RECT_WAVE_GEN_CYCLES_EN
                cyc_d   = '0;
`endif
            end
        end else if (stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            dout_d  = iv_q;
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_ONE;
            dout_d = level(state_q, cnt_d, dout_q, iv_q, pv_q, sr_q, sf_q);
        end else begin
            nxt     = pick(3'(state_q) + 3'd1, nz_q, per_q);
            state_d = nxt;
            cnt_d   = (nxt == S_IDLE) ? '0 : dur_of(nxt, td_q, tr_q, th_q, tf_q, tl_q) - CNT_ONE;
            dout_d  = level(nxt, cnt_d, dout_q, iv_q, pv_q, sr_q, sf_q);
            done_d  = (nxt == S_IDLE) && !per_q;
`ifdef RECT_WAVE_GEN_CYCLES_EN
            // Moving backwards in the state order means one full period has finished.
            if (nxt != S_IDLE && nxt <= state_q && cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            iv_q <= '0; pv_q <= '0; sr_q <= '0; sf_q <= '0;
            td_q <= '0; tr_q <= '0; th_q <= '0; tf_q <= '0; tl_q <= '0;
            per_q   <= 1'b0;
`ifdef RECT_WAVE_GEN_CYCLES_EN
            cyc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            iv_q <= iv_d; pv_q <= pv_d; sr_q <= sr_d; sf_q <= sf_d;
            td_q <= td_d; tr_q <= tr_d; th_q <= th_d; tf_q <= tf_d; tl_q <= tl_d;
            per_q   <= per_d;
`ifdef RECT_WAVE_GEN_CYCLES_EN
            cyc_q   <= cyc_d;
`endif
        end
    end

    assign dout  = dout_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign phase = 3'(state_q);
`ifdef RECT_WAVE_GEN_CYCLES_EN
    assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_rect_wave_gen.sv
// Scoreboard bench for rect_wave_gen: directed runs push cycle-tagged expectations, a negedge monitor checks them.
module tb_rect_wave_gen;
    localparam int DW = 12;
    localparam int CW = 16;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, periodic = 1'b0;
    logic [DW-1:0] iv = '0, pv = '0, step_r = '0, step_f = '0;
    logic [CW-1:0] td = '0, tr = '0, th = '0, tf = '0, tl = '0;
    logic [DW-1:0] dout;
    logic          busy, done;
    logic [2:0]    phase;
`ifdef RECT_WAVE_GEN_CYCLES_EN
    logic [15:0]   cycles;
`endif

    rect_wave_gen #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
        .iv(iv), .pv(pv), .step_r(step_r), .step_f(step_f),
        .td(td), .tr(tr), .th(th), .tf(tf), .tl(tl),
        .dout(dout), .busy(busy), .done(done), .phase(phase)
`ifdef RECT_WAVE_GEN_CYCLES_EN
        , .cycles(cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          tid;
        int          k;
        logic [11:0] dout;
        logic [2:0]  ph;
        logic        bsy;
        logic        dn;
        logic [15:0] cy;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   base = 0, tid = 0;
    bit   drain = 0, drained = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        bit   bad;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            bad = (e.cyc != cyc) || (dout !== e.dout) || (phase !== e.ph) ||
                  (busy !== e.bsy) || (done !== e.dn);
`ifdef RECT_WAVE_GEN_CYCLES_EN
            if (cycles !== e.cy) bad = 1'b1;
`endif
            if (bad) begin
                errors++;
                $display("FAIL t%0d_k%0d at cyc %0d (due %0d): got dout=%0d phase=%0d busy=%0b done=%0b, want dout=%0d phase=%0d busy=%0b done=%0b cycles=%0d",
                         e.tid, e.k, cyc, e.cyc, dout, phase, busy, done, e.dout, e.ph, e.bsy, e.dn, e.cy);
            end
        end
        if (drain && !drained) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
            end
            drained = 1;
        end
    end

    task automatic push(input int k, input int d, input int ph, input int b, input int dn, input int cy);
        exp_t e;
        e.cyc = base + k; e.tid = tid; e.k = k;
        e.dout = 12'(d); e.ph = 3'(ph); e.bsy = b[0]; e.dn = dn[0]; e.cy = 16'(cy);
        q.push_back(e);
    endtask

    // Drive a config with start (and optionally stop) high during cycle 'base'.
    task automatic go(input int id, input int p, input int i_v, input int p_v, input int sr, input int sf,
                      input int d0, input int d1, input int d2, input int d3, input int d4, input int stp);
        @(negedge clk);
        base = cyc; tid = id;
        periodic = p[0]; iv = 12'(i_v); pv = 12'(p_v); step_r = 12'(sr); step_f = 12'(sf);
        td = 16'(d0); tr = 16'(d1); th = 16'(d2); tf = 16'(d3); tl = 16'(d4);
        start = 1'b1; stop = stp[0];
    endtask

    // Drop start/stop and scramble every config input: latched values must govern the run.
    task automatic tick();
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        iv = 12'd3333; pv = 12'd1; step_r = 12'd4000; step_f = 12'd4000;
        td = 16'd9; tr = 16'd9; th = 16'd9; tf = 16'd9; tl = 16'd9;
        periodic = ~periodic;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_basic();
        push(1, 100, 1, 1, 0, 0);  push(2, 100, 1, 1, 0, 0);
        push(3, 400, 2, 1, 0, 0);  push(4, 700, 2, 1, 0, 0);  push(5, 1000, 2, 1, 0, 0);
        push(6, 1000, 3, 1, 0, 0); push(7, 1000, 3, 1, 0, 0);
        push(8, 100, 4, 1, 0, 0);
        push(9, 100, 0, 0, 1, 0);  push(10, 100, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        push(1, 0, 0, 0, 0, 0); push(2, 0, 0, 0, 0, 0);
        #22 rst = 1'b0;

        // Basic single pulse; a start while busy must not restart
        go(1, 0, 100, 1000, 300, 50, 2, 3, 2, 1, 0, 0);
        exp_basic();
        tick();
        idle(2);
        start = 1'b1; iv = 12'd7; td = '0; tr = 16'd1;
        idle(1);
        start = 1'b0;
        idle(8);

        // Downward rise ramp, no wrap below zero
        go(2, 0, 4000, 10, 1000, 0, 0, 4, 0, 0, 0, 0);
        push(1, 3000, 2, 1, 0, 0); push(2, 2000, 2, 1, 0, 0);
        push(3, 1000, 2, 1, 0, 0); push(4, 10, 2, 1, 0, 0);
        push(5, 4000, 0, 0, 1, 0); push(6, 4000, 0, 0, 0, 0);
        tick(); idle(6);

        // Clamp at the top code on rise, oversized fall step clamps at iv
        go(3, 0, 4090, 4095, 10, 4095, 0, 2, 1, 2, 0, 0);
        push(1, 4095, 2, 1, 0, 0); push(2, 4095, 2, 1, 0, 0); push(3, 4095, 3, 1, 0, 0);
        push(4, 4090, 4, 1, 0, 0); push(5, 4090, 4, 1, 0, 0);
        push(6, 4090, 0, 0, 1, 0); push(7, 4090, 0, 0, 0, 0);
        tick(); idle(7);

        // All durations zero: single pulse completes at once, periodic stays idle
        go(4, 0, 321, 900, 5, 5, 0, 0, 0, 0, 0, 0);
        push(1, 321, 0, 0, 1, 0); push(2, 321, 0, 0, 0, 0);
        tick(); idle(2);
        go(5, 1, 77, 900, 5, 5, 0, 0, 0, 0, 0, 0);
        push(1, 77, 0, 0, 0, 0); push(2, 77, 0, 0, 0, 0);
        tick(); idle(2);

        // Periodic: delay once then 2,3,4,5 repeating; stop in HIGH
        go(6, 1, 50, 800, 500, 500, 1, 1, 1, 1, 1, 0);
        push(1, 50, 1, 1, 0, 0);
        push(2, 800, 2, 1, 0, 0); push(3, 800, 3, 1, 0, 0); push(4, 50, 4, 1, 0, 0); push(5, 50, 5, 1, 0, 0);
        push(6, 800, 2, 1, 0, 1); push(7, 800, 3, 1, 0, 1); push(8, 50, 4, 1, 0, 1); push(9, 50, 5, 1, 0, 1);
        push(10, 800, 2, 1, 0, 2); push(11, 800, 3, 1, 0, 2);
        push(12, 50, 0, 0, 0, 2); push(13, 50, 0, 0, 0, 2);
        tick(); idle(10);
        stop = 1'b1;
        idle(1);
        stop = 1'b0;
        idle(3);

        // start and stop together in IDLE: stop wins, nothing latched
        go(7, 0, 999, 999, 1, 1, 3, 1, 1, 1, 0, 1);
        push(1, 50, 0, 0, 0, 2); push(2, 50, 0, 0, 0, 2);
        tick(); idle(2);

        // Asynchronous reset mid-RISE, then a clean rerun
        go(8, 0, 100, 1000, 300, 50, 2, 3, 2, 1, 0, 0);
        push(1, 100, 1, 1, 0, 0); push(2, 100, 1, 1, 0, 0); push(3, 400, 2, 1, 0, 0);
        tick();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        push(4, 0, 0, 0, 0, 0); push(5, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        go(9, 0, 100, 1000, 300, 50, 2, 3, 2, 1, 0, 0);
        exp_basic();
        tick(); idle(10);

        drain = 1;
        for (int i = 0; i < 5 && !drained; i++) @(negedge clk);
        if (!drained) begin
            $display("FAIL drain: monitor never completed final check");
            $fatal(1, "drain");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
